pad_bus_ctrl: RTL and testbench

Half-duplex controller for a shared off-chip bus built from bidirectional, output and input pad cells. It arbitrates between an internal transmit requester and an internal receive requester, sequences the pad enables with guaranteed turnaround gaps, generates and detects strobes, and times out stalled receives. It sits between core logic and the pad ring and is the only driver of the bidirectional pad EN pins.

---
 rtl/pad_bus_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pad_bus_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_bus_ctrl.sv
// pad_bus_ctrl: half-duplex arbiter and pad sequencer for a shared bidirectional off-chip bus.
// Latency: TX strobe 1 cycle after accept (TURN+1 on a direction change); rx_valid 3 cycles after a synchronous remote strobe rise.
// Backpressure: tx_ready/rx_ack are offered only in IDLE to one winner; everything else waits while busy.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   tx_valid/tx_data/tx_ready   transmit word handshake (tx_ready combinational)
//   rx_req/rx_ack               receive request handshake (rx_ack combinational)
//   rx_valid/rx_data/rx_timeout receive result pulses; rx_data holds until the next capture
//   pad_dout/pad_din/pad_en     bidirectional pad DataOut/DataIn/EN (EN=1: chip drives)
//   pad_dir_o/pad_stb_o         direction and strobe output pads
//   pad_stb_i                   remote strobe, asynchronous to clk
//   busy                        FSM is not idle
module pad_bus_ctrl #(
  parameter int WIDTH = 8,
  parameter int TURN  = 2,
  parameter int TMO   = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_valid,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ready,
  input  logic             rx_req,
  output logic             rx_ack,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_timeout,
  output logic [WIDTH-1:0] pad_dout,
  input  logic [WIDTH-1:0] pad_din,
  output logic             pad_en,
  output logic             pad_dir_o,
  output logic             pad_stb_o,
  input  logic             pad_stb_i,
  output logic             busy
);

  localparam int TW = $clog2(TURN + 1);
  localparam int MW = $clog2(TMO + 1);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN - 1);
  localparam logic [MW-1:0] TMO_LAST  = MW'(TMO - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TURN,
    S_TX_STB,
    S_TX_HOLD,
    S_RX_WAIT
  } state_t;

  state_t           state, state_nxt;
  logic             dir;        // 0 = RX, 1 = TX
  logic             pend_dir;   // direction being switched to while in TURN
  logic             last_tx;    // last grant was TX; loses the next tie
  logic [TW-1:0]    turn_cnt;
  logic [MW-1:0]    tmo_cnt;
  logic [2:0]       stb_sync;   // [1:0] synchronizer, [2] previous value for edge detect
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] rx_data_q;
  logic             rx_valid_q;
  logic             rx_timeout_q;

  logic tx_win, rx_win, stb_edge, tmo_hit;

  // Tie goes to the side that was not granted last.
  assign tx_win   = tx_valid & (~rx_req | ~last_tx);
  assign rx_win   = rx_req & (~tx_valid | last_tx);
  assign stb_edge = stb_sync[1] & ~stb_sync[2];
  assign tmo_hit  = (tmo_cnt == TMO_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (tx_win)      state_nxt = dir ? S_TX_STB : S_TURN;
        else if (rx_win) state_nxt = dir ? S_TURN : S_RX_WAIT;
      end
      S_TURN: begin
        if (turn_cnt == TURN_LAST) state_nxt = pend_dir ? S_TX_STB : S_RX_WAIT;
      end
      S_TX_STB:  state_nxt = S_TX_HOLD;
      S_TX_HOLD: state_nxt = S_IDLE;
      S_RX_WAIT: begin
        // A strobe edge takes priority over a coincident timeout.
        if (stb_edge || tmo_hit) state_nxt = S_IDLE;
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output decode: registers only, apart from the two handshake grants.
  always_comb begin
    tx_ready  = (state == S_IDLE) & tx_win;
    rx_ack    = (state == S_IDLE) & rx_win;
    pad_en    = dir & (state != S_TURN);
    pad_dir_o = (state == S_TURN) ? pend_dir : dir;
    pad_stb_o = (state == S_TX_STB) | (state == S_RX_WAIT);
    busy      = (state != S_IDLE);
  end

  assign pad_dout   = dout_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_timeout = rx_timeout_q;

  // Datapath, counters and direction bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir          <= 1'b0;
      pend_dir     <= 1'b0;
      last_tx      <= 1'b0;
      turn_cnt     <= '0;
      tmo_cnt      <= '0;
      stb_sync     <= '0;
      dout_q       <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_timeout_q <= 1'b0;
    end else begin
      stb_sync     <= {stb_sync[1:0], pad_stb_i};
      rx_valid_q   <= 1'b0;
      rx_timeout_q <= 1'b0;
      if (state != S_TURN)    turn_cnt <= '0;
      if (state != S_RX_WAIT) tmo_cnt  <= '0;
      case (state)
        S_IDLE: begin
          if (tx_win) begin
            dout_q   <= tx_data;
            last_tx  <= 1'b1;
            pend_dir <= 1'b1;
          end else if (rx_win) begin
            last_tx  <= 1'b0;
            pend_dir <= 1'b0;
          end
        end
        S_TURN: begin
          if (turn_cnt == TURN_LAST) dir <= pend_dir;
          else                       turn_cnt <= turn_cnt + 1'b1;
        end
        S_RX_WAIT: begin
          if (stb_edge) begin
            rx_data_q  <= pad_din;
            rx_valid_q <= 1'b1;
          end else if (tmo_hit) begin
            rx_timeout_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pad_bus_ctrl.sv
// tb_pad_bus_ctrl: directed and randomized transactions against a transaction-level timeline model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_pad_bus_ctrl;
  localparam int WIDTH = 8;
  localparam int TURN  = 2;
  localparam int TMO   = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             tx_valid = 1'b0;
  logic [WIDTH-1:0] tx_data = '0;
  logic             tx_ready;
  logic             rx_req = 1'b0;
  logic             rx_ack, rx_valid, rx_timeout;
  logic [WIDTH-1:0] rx_data, pad_dout;
  logic [WIDTH-1:0] pad_din = '0;
  logic             pad_en, pad_dir_o, pad_stb_o, busy;
  logic             pad_stb_i = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: bus direction, tie-break history, last captured word.
  bit               m_dir;
  bit               m_last_tx;
  logic [WIDTH-1:0] m_rx_data;

  always #5 clk = ~clk;

  pad_bus_ctrl #(.WIDTH(WIDTH), .TURN(TURN), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_req(rx_req), .rx_ack(rx_ack),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_timeout(rx_timeout),
    .pad_dout(pad_dout), .pad_din(pad_din), .pad_en(pad_en),
    .pad_dir_o(pad_dir_o), .pad_stb_o(pad_stb_o), .pad_stb_i(pad_stb_i),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic no_grant(input string tag);
    check({tag, "_txrdy"}, tx_ready, 0);
    check({tag, "_rxack"}, rx_ack, 0);
  endtask

  task automatic idle_check(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_en"}, pad_en, m_dir);
    check({tag, "_dir"}, pad_dir_o, m_dir);
    check({tag, "_stb"}, pad_stb_o, 0);
  endtask

  // Called at a negedge with the DUT idle; leaves requests asserted through the transaction.
  task automatic request(input bit want_tx, input bit want_rx, input logic [WIDTH-1:0] d,
                         output bit got_tx);
    tx_valid = want_tx;
    rx_req   = want_rx;
    tx_data  = d;
    #1;
    got_tx = want_tx && (!want_rx || !m_last_tx);
    check("grant_tx", tx_ready, got_tx);
    check("grant_rx", rx_ack, want_rx && !got_tx);
    m_last_tx = got_tx;
    nxt();
    tx_data = ~d;  // word was latched at accept; later changes must not reach the pads
  endtask

  task automatic tx_timeline(input logic [WIDTH-1:0] d);
    if (!m_dir) begin
      for (int i = 0; i < TURN; i++) begin
        check("tx_turn_en", pad_en, 0);
        check("tx_turn_dir", pad_dir_o, 1);
        check("tx_turn_busy", busy, 1);
        check("tx_turn_stb", pad_stb_o, 0);
        no_grant("tx_turn");
        nxt();
      end
      m_dir = 1'b1;
    end
    check("tx_stb_en", pad_en, 1);
    check("tx_stb_dir", pad_dir_o, 1);
    check("tx_stb", pad_stb_o, 1);
    check("tx_stb_dout", pad_dout, d);
    no_grant("tx_stb");
    nxt();
    check("tx_hold_en", pad_en, 1);
    check("tx_hold_stb", pad_stb_o, 0);
    check("tx_hold_busy", busy, 1);
    check("tx_hold_dout", pad_dout, d);
    nxt();
    idle_check("tx_done");
    check("tx_park_dout", pad_dout, d);
    tx_valid = 1'b0;
    rx_req   = 1'b0;
  endtask

  // Remote raises pad_stb_i dly cycles into RX_WAIT (if strobe); the edge is seen
  // two cycles later and rx_valid one after that, unless the TMO-cycle window has closed.
  task automatic rx_timeline(input logic [WIDTH-1:0] d, input bit strobe, input int dly);
    bit hit;
    int last;
    if (m_dir) begin
      for (int i = 0; i < TURN; i++) begin
        check("rx_turn_en", pad_en, 0);
        check("rx_turn_dir", pad_dir_o, 0);
        check("rx_turn_busy", busy, 1);
        check("rx_turn_stb", pad_stb_o, 0);
        no_grant("rx_turn");
        nxt();
      end
      m_dir = 1'b0;
    end
    hit  = strobe && (dly + 2 <= TMO - 1);
    last = hit ? dly + 3 : TMO;
    for (int k = 0; k <= last; k++) begin
      if (k < last) begin
        check("rx_wait_stb", pad_stb_o, 1);
        check("rx_wait_busy", busy, 1);
        check("rx_wait_en", pad_en, 0);
        check("rx_wait_valid", rx_valid, 0);
        check("rx_wait_tmo", rx_timeout, 0);
        no_grant("rx_wait");
      end else begin
        check("rx_end_valid", rx_valid, hit);
        check("rx_end_tmo", rx_timeout, !hit);
        check("rx_end_busy", busy, 0);
      end
      if (strobe && k == dly) begin
        pad_din   = d;
        pad_stb_i = 1'b1;
      end
      if (k < last) nxt();
    end
    if (hit) m_rx_data = d;
    check("rx_data", rx_data, m_rx_data);
    tx_valid  = 1'b0;
    rx_req    = 1'b0;
    pad_stb_i = 1'b0;
    nxt();
    check("rx_pulse_valid", rx_valid, 0);
    check("rx_pulse_tmo", rx_timeout, 0);
    idle_check("rx_done");
    pad_din = WIDTH'($urandom);
  endtask

  task automatic run_one(input bit want_tx, input bit want_rx);
    bit g;
    logic [WIDTH-1:0] td, rd;
    td = WIDTH'($urandom);
    rd = WIDTH'($urandom);
    request(want_tx, want_rx, td, g);
    if (g) tx_timeline(td);
    else   rx_timeline(rd, $urandom_range(0, 3) != 0, $urandom_range(0, TMO - 1));
  endtask

  initial begin
    bit g;
    m_dir = 1'b0; m_last_tx = 1'b0; m_rx_data = '0;

    #1;
    check("rst_en", pad_en, 0);
    check("rst_busy", busy, 0);
    check("rst_stb", pad_stb_o, 0);
    check("rst_dir", pad_dir_o, 0);
    check("rst_dout", pad_dout, 0);
    check("rst_rxdata", rx_data, 0);
    check("rst_rxvalid", rx_valid, 0);
    check("rst_rxtmo", rx_timeout, 0);
    repeat (2) nxt();
    rst_n = 1'b1;
    nxt();
    idle_check("post_rst");

    // First TX with a turnaround, then two back-to-back parked-bus words.
    request(1, 0, 8'hA5, g); tx_timeline(8'hA5);
    request(1, 0, 8'h5A, g); tx_timeline(8'h5A);
    request(1, 0, 8'hC3, g); tx_timeline(8'hC3);
    // Receive after TX, then timeout, edge/timeout coincidence, and a too-late edge.
    request(0, 1, 8'h00, g); rx_timeline(8'h3C, 1, 5);
    request(0, 1, 8'h00, g); rx_timeline(8'h77, 0, 0);
    request(0, 1, 8'h00, g); rx_timeline(8'h96, 1, TMO - 3);
    request(0, 1, 8'h00, g); rx_timeline(8'h69, 1, TMO - 1);

    // Reset while strobing a TX word.
    request(1, 0, 8'hE1, g);
    if (!m_dir) repeat (TURN) nxt();
    check("rtx_pre_stb", pad_stb_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rtx_en", pad_en, 0);
    check("rtx_stb", pad_stb_o, 0);
    check("rtx_busy", busy, 0);
    check("rtx_dir", pad_dir_o, 0);
    check("rtx_dout", pad_dout, 0);
    m_dir = 1'b0; m_last_tx = 1'b0; m_rx_data = '0;
    tx_valid = 1'b0; rx_req = 1'b0;
    nxt();
    rst_n = 1'b1;
    nxt();
    idle_check("rtx_after");

    // Reset while waiting for a receive, with the remote strobe left high.
    request(0, 1, 8'h00, g);
    repeat (3) nxt();
    check("rrx_pre_stb", pad_stb_o, 1);
    check("rrx_pre_busy", busy, 1);
    pad_stb_i = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rrx_en", pad_en, 0);
    check("rrx_stb", pad_stb_o, 0);
    check("rrx_busy", busy, 0);
    check("rrx_rxdata", rx_data, 0);
    m_dir = 1'b0; m_last_tx = 1'b0; m_rx_data = '0;
    rx_req = 1'b0;
    nxt();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nxt();
      check("stale_valid", rx_valid, 0);
      idle_check("stale_idle");
    end
    request(0, 1, 8'h00, g);
    rx_timeline(8'h00, 0, 0);

    // Both sides requesting together: grants must alternate.
    for (int i = 0; i < 6; i++) run_one(1, 1);

    // Randomized mix of TX-only, RX-only and tied requests with idle gaps.
    for (int i = 0; i < 40; i++) begin
      int kind;
      int gap;
      gap = $urandom_range(0, 2);
      for (int j = 0; j < gap; j++) begin
        idle_check("gap");
        nxt();
      end
      kind = $urandom_range(0, 2);
      run_one(kind != 1, kind != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
